// File: rtl/cache_req_dispatch_pkg.sv
// rtl/cache_req_dispatch_pkg.sv - shared cache request helpers and width functions
package cache_req_dispatch_pkg;

    // Width of the scratch vector the address helpers operate on.
    localparam int ADDR_CALC_WIDTH = 64;

    // Index width that stays at least one bit even for a single entry.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of address bits consumed by bank selection (0 for a single bank).
    function automatic int bank_sel_bits(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Lane index width carried with each bank request.
    function automatic int req_sel_bits(input int num_reqs);
        return log2up(num_reqs);
    endfunction

    // Low address bits pick the bank.
    function automatic logic [ADDR_CALC_WIDTH-1:0] bank_sel_of(
        input logic [ADDR_CALC_WIDTH-1:0] addr,
        input int                         sel_bits
    );
        return addr & ((64'd1 << sel_bits) - 64'd1);
    endfunction

    // Remaining upper bits address the word inside the bank.
    function automatic logic [ADDR_CALC_WIDTH-1:0] bank_addr_of(
        input logic [ADDR_CALC_WIDTH-1:0] addr,
        input int                         sel_bits
    );
        return addr >> sel_bits;
    endfunction

endpackage

// File: rtl/cache_req_rr_arbiter.sv
// rtl/cache_req_rr_arbiter.sv - round-robin lane arbiter for one cache bank
module cache_req_rr_arbiter
    import cache_req_dispatch_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                accept,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    logic [IDX_BITS-1:0] rr_ptr;

    // Search upward from the pointer with wrap; the first requesting lane wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQS;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_BITS'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when the grant is actually taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= IDX_BITS'((int'(grant_idx) + 1) % NUM_REQS);
        end
    end

endmodule

// File: rtl/cache_req_dispatch.sv
// rtl/cache_req_dispatch.sv - steers core lane requests to cache banks with per-bank RR and output stage
module cache_req_dispatch
    import cache_req_dispatch_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int NUM_BANKS  = 2,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    localparam int WORD_WIDTH      = WORD_SIZE * 8,
    localparam int BANK_SEL_BITS   = bank_sel_bits(NUM_BANKS),
    localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_SEL_BITS,
    localparam int REQ_SEL_BITS    = req_sel_bits(NUM_REQS)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQS-1:0]                         core_req_valid,
    input  logic [NUM_REQS-1:0]                         core_req_rw,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]         core_req_addr,
    input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]          core_req_byteen,
    input  logic [NUM_REQS-1:0][WORD_WIDTH-1:0]         core_req_data,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]          core_req_tag,
    output logic [NUM_REQS-1:0]                         core_req_ready,
    output logic [NUM_BANKS-1:0]                        per_bank_core_req_valid,
    output logic [NUM_BANKS-1:0]                        per_bank_core_req_rw,
    output logic [NUM_BANKS-1:0][BANK_ADDR_WIDTH-1:0]   per_bank_core_req_addr,
    output logic [NUM_BANKS-1:0][WORD_SIZE-1:0]         per_bank_core_req_byteen,
    output logic [NUM_BANKS-1:0][WORD_WIDTH-1:0]        per_bank_core_req_data,
    output logic [NUM_BANKS-1:0][TAG_WIDTH-1:0]         per_bank_core_req_tag,
    output logic [NUM_BANKS-1:0][REQ_SEL_BITS-1:0]      per_bank_core_req_idx,
    input  logic [NUM_BANKS-1:0]                        per_bank_core_req_ready
);

    localparam int BANK_IDX_BITS = log2up(NUM_BANKS);

    if ((NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_num_banks
        $error("NUM_BANKS must be a power of 2");
    end
    if (NUM_BANKS > NUM_REQS) begin : g_bad_num_reqs
        $error("NUM_BANKS must not exceed NUM_REQS");
    end

    logic [NUM_REQS-1:0][BANK_IDX_BITS-1:0]   lane_bank;
    logic [NUM_REQS-1:0][BANK_ADDR_WIDTH-1:0] lane_bank_addr;
    logic [NUM_BANKS-1:0][NUM_REQS-1:0]       bank_req;
    logic [NUM_BANKS-1:0][NUM_REQS-1:0]       grant;
    logic [NUM_BANKS-1:0][REQ_SEL_BITS-1:0]   grant_idx;
    logic [NUM_BANKS-1:0]                     grant_valid;
    logic [NUM_BANKS-1:0]                     stage_valid;
    logic [NUM_BANKS-1:0]                     stage_can_load;
    logic [NUM_BANKS-1:0]                     bank_accept;

    // Split each lane address into bank select and in-bank address, then group requesters by bank.
    always_comb begin
        lane_bank      = '0;
        lane_bank_addr = '0;
        bank_req       = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            lane_bank[r]      = BANK_IDX_BITS'(bank_sel_of(ADDR_CALC_WIDTH'(core_req_addr[r]), BANK_SEL_BITS));
            lane_bank_addr[r] = BANK_ADDR_WIDTH'(bank_addr_of(ADDR_CALC_WIDTH'(core_req_addr[r]), BANK_SEL_BITS));
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int r = 0; r < NUM_REQS; r++) begin
                bank_req[b][r] = core_req_valid[r] && (int'(lane_bank[r]) == b);
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_arb
        cache_req_rr_arbiter #(
            .NUM_REQS (NUM_REQS),
            .IDX_BITS (REQ_SEL_BITS)
        ) u_arb (
            .clk         (clk),
            .reset       (reset),
            .req         (bank_req[b]),
            .accept      (bank_accept[b]),
            .grant       (grant[b]),
            .grant_idx   (grant_idx[b]),
            .grant_valid (grant_valid[b])
        );
    end

    // A grant is taken only when the bank stage is free or draining this cycle; reset blocks all accepts.
    always_comb begin
        stage_can_load = ~stage_valid | per_bank_core_req_ready;
        bank_accept    = '0;
        core_req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_accept[b] = reset && grant_valid[b] && stage_can_load[b];
            for (int r = 0; r < NUM_REQS; r++) begin
                if (grant[b][r] && bank_accept[b]) begin
                    core_req_ready[r] = 1'b1;
                end
            end
        end
    end

    // Per-bank output stage: load on accept (replacing a firing entry without a bubble), hold on stall, drain otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_valid <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_accept[b]) begin
                    stage_valid[b]              <= 1'b1;
                    per_bank_core_req_rw[b]     <= core_req_rw[grant_idx[b]];
                    per_bank_core_req_addr[b]   <= lane_bank_addr[grant_idx[b]];
                    per_bank_core_req_byteen[b] <= core_req_byteen[grant_idx[b]];
                    per_bank_core_req_data[b]   <= core_req_data[grant_idx[b]];
                    per_bank_core_req_tag[b]    <= core_req_tag[grant_idx[b]];
                    per_bank_core_req_idx[b]    <= grant_idx[b];
                end else if (per_bank_core_req_ready[b]) begin
                    stage_valid[b] <= 1'b0;
                end
            end
        end
    end

    assign per_bank_core_req_valid = stage_valid;

endmodule

// File: tb/tb_cache_req_dispatch.sv
// tb/tb_cache_req_dispatch.sv - directed self-checking bench for cache_req_dispatch
module tb_cache_req_dispatch;

    localparam int NR  = 4;
    localparam int NB  = 2;
    localparam int AW  = 30;
    localparam int BAW = 29;
    localparam int RSB = 2;

    logic clk;
    logic reset;

    logic [NR-1:0]            core_req_valid;
    logic [NR-1:0]            core_req_rw;
    logic [NR-1:0][AW-1:0]    core_req_addr;
    logic [NR-1:0][3:0]       core_req_byteen;
    logic [NR-1:0][31:0]      core_req_data;
    logic [NR-1:0][7:0]       core_req_tag;
    logic [NR-1:0]            core_req_ready;
    logic [NB-1:0]            bk_valid;
    logic [NB-1:0]            bk_rw;
    logic [NB-1:0][BAW-1:0]   bk_addr;
    logic [NB-1:0][3:0]       bk_byteen;
    logic [NB-1:0][31:0]      bk_data;
    logic [NB-1:0][7:0]       bk_tag;
    logic [NB-1:0][RSB-1:0]   bk_idx;
    logic [NB-1:0]            bk_ready;

    logic [1:0]               s_valid;
    logic [1:0]               s_rw;
    logic [1:0][AW-1:0]       s_addr;
    logic [1:0][3:0]          s_byteen;
    logic [1:0][31:0]         s_data;
    logic [1:0][7:0]          s_tag;
    logic [1:0]               s_ready;
    logic [0:0]               s_bk_valid;
    logic [0:0]               s_bk_rw;
    logic [0:0][AW-1:0]       s_bk_addr;
    logic [0:0][3:0]          s_bk_byteen;
    logic [0:0][31:0]         s_bk_data;
    logic [0:0][7:0]          s_bk_tag;
    logic [0:0][0:0]          s_bk_idx;
    logic [0:0]               s_bk_ready;

    int n_vec = 0;
    int n_mis = 0;

    cache_req_dispatch dut (
        .clk                      (clk),
        .reset                    (reset),
        .core_req_valid           (core_req_valid),
        .core_req_rw              (core_req_rw),
        .core_req_addr            (core_req_addr),
        .core_req_byteen          (core_req_byteen),
        .core_req_data            (core_req_data),
        .core_req_tag             (core_req_tag),
        .core_req_ready           (core_req_ready),
        .per_bank_core_req_valid  (bk_valid),
        .per_bank_core_req_rw     (bk_rw),
        .per_bank_core_req_addr   (bk_addr),
        .per_bank_core_req_byteen (bk_byteen),
        .per_bank_core_req_data   (bk_data),
        .per_bank_core_req_tag    (bk_tag),
        .per_bank_core_req_idx    (bk_idx),
        .per_bank_core_req_ready  (bk_ready)
    );

    cache_req_dispatch #(
        .NUM_REQS  (2),
        .NUM_BANKS (1)
    ) dut_one_bank (
        .clk                      (clk),
        .reset                    (reset),
        .core_req_valid           (s_valid),
        .core_req_rw              (s_rw),
        .core_req_addr            (s_addr),
        .core_req_byteen          (s_byteen),
        .core_req_data            (s_data),
        .core_req_tag             (s_tag),
        .core_req_ready           (s_ready),
        .per_bank_core_req_valid  (s_bk_valid),
        .per_bank_core_req_rw     (s_bk_rw),
        .per_bank_core_req_addr   (s_bk_addr),
        .per_bank_core_req_byteen (s_bk_byteen),
        .per_bank_core_req_data   (s_bk_data),
        .per_bank_core_req_tag    (s_bk_tag),
        .per_bank_core_req_idx    (s_bk_idx),
        .per_bank_core_req_ready  (s_bk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b0;
        core_req_valid = '0;
        bk_ready       = '0;
        s_valid        = '0;
        s_addr         = '0;
        s_bk_ready     = 1'b0;
        for (int r = 0; r < NR; r++) begin
            core_req_rw[r]     = r[0];
            core_req_addr[r]   = '0;
            core_req_byteen[r] = 4'hF;
            core_req_data[r]   = 32'hD000_0000 + 32'(r);
            core_req_tag[r]    = 8'hA0 + 8'(r);
        end
        for (int r = 0; r < 2; r++) begin
            s_rw[r]     = 1'b0;
            s_byteen[r] = 4'h3;
            s_data[r]   = 32'h5000_0000 + 32'(r);
            s_tag[r]    = 8'h50 + 8'(r);
        end

        // Reset state; a valid lane must see ready low while reset is held.
        core_req_valid = 4'b0001;
        bk_ready       = 2'b11;
        tick;
        tick;
        chk("reset_bank_valid", 64'(bk_valid), 64'h0);
        chk("reset_core_ready", 64'(core_req_ready), 64'h0);
        reset          = 1'b1;
        core_req_valid = '0;
        tick;

        // No conflict: lanes 0 and 1 to different banks.
        core_req_addr[0] = 30'h10;
        core_req_addr[1] = 30'h11;
        core_req_valid   = 4'b0011;
        #1;
        chk("nc_ready", 64'(core_req_ready), 64'h3);
        tick;
        core_req_valid = '0;
        chk("nc_valid", 64'(bk_valid), 64'h3);
        chk("nc_idx0", 64'(bk_idx[0]), 64'h0);
        chk("nc_idx1", 64'(bk_idx[1]), 64'h1);
        chk("nc_addr0", 64'(bk_addr[0]), 64'h8);
        chk("nc_addr1", 64'(bk_addr[1]), 64'h8);
        chk("nc_data1", 64'(bk_data[1]), 64'hD000_0001);
        chk("nc_tag0", 64'(bk_tag[0]), 64'hA0);
        chk("nc_rw1", 64'(bk_rw[1]), 64'h1);
        tick;
        chk("nc_drain", 64'(bk_valid), 64'h0);

        // Clear pointers before the fairness run.
        reset = 1'b0;
        tick;
        reset = 1'b1;

        // Conflict fairness: all four lanes to bank 0, served 0,1,2,3.
        for (int r = 0; r < NR; r++) core_req_addr[r] = 30'(2 * r);
        core_req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 64'(core_req_ready), 64'(1 << k));
            tick;
            chk("rr_idx0", 64'(bk_idx[0]), 64'(k));
            chk("rr_addr0", 64'(bk_addr[0]), 64'(k));
            chk("rr_bank1_idle", 64'(bk_valid[1]), 64'h0);
        end
        core_req_valid = '0;
        tick;
        chk("rr_drain", 64'(bk_valid), 64'h0);

        // Stall: lane 2 buffered in bank 1, bank 1 not ready for 3 cycles, lane 3 waiting.
        bk_ready         = 2'b01;
        core_req_addr[2] = 30'h21;
        core_req_valid   = 4'b0100;
        #1;
        chk("st_ready_load", 64'(core_req_ready), 64'h4);
        tick;
        core_req_addr[3] = 30'h33;
        core_req_valid   = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_ready_blocked", 64'(core_req_ready), 64'h0);
            chk("st_valid1", 64'(bk_valid[1]), 64'h1);
            chk("st_idx1", 64'(bk_idx[1]), 64'h2);
            chk("st_addr1", 64'(bk_addr[1]), 64'h10);
            chk("st_tag1", 64'(bk_tag[1]), 64'hA2);
            tick;
        end
        bk_ready = 2'b11;
        #1;
        chk("st_release_ready", 64'(core_req_ready), 64'h8);
        tick;
        core_req_valid = '0;
        chk("st_next_valid1", 64'(bk_valid[1]), 64'h1);
        chk("st_next_idx1", 64'(bk_idx[1]), 64'h3);
        chk("st_next_addr1", 64'(bk_addr[1]), 64'h19);
        tick;
        chk("st_drain", 64'(bk_valid), 64'h0);

        // Pointer hold: bank 0 pointer at 1, lane 1 granted while stalled.
        bk_ready         = 2'b00;
        core_req_addr[0] = 30'h40;
        core_req_valid   = 4'b0001;
        #1;
        chk("ph_ready_l0", 64'(core_req_ready), 64'h1);
        tick;
        core_req_addr[1] = 30'h02;
        core_req_addr[2] = 30'h04;
        core_req_valid   = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("ph_ready_stall", 64'(core_req_ready), 64'h0);
            chk("ph_idx_held", 64'(bk_idx[0]), 64'h0);
            tick;
        end
        bk_ready = 2'b01;
        #1;
        chk("ph_ready_l1", 64'(core_req_ready), 64'h2);
        tick;
        chk("ph_idx_l1", 64'(bk_idx[0]), 64'h1);
        chk("ph_addr_l1", 64'(bk_addr[0]), 64'h1);
        core_req_valid = 4'b0100;
        #1;
        chk("ph_ready_l2", 64'(core_req_ready), 64'h4);
        tick;
        chk("ph_idx_l2", 64'(bk_idx[0]), 64'h2);
        chk("ph_addr_l2", 64'(bk_addr[0]), 64'h2);
        core_req_valid = '0;
        tick;
        chk("ph_drain", 64'(bk_valid), 64'h0);

        // Reset mid-traffic with both banks holding requests.
        bk_ready         = 2'b00;
        core_req_addr[0] = 30'h00;
        core_req_addr[1] = 30'h01;
        core_req_valid   = 4'b0011;
        #1;
        chk("mr_ready_load", 64'(core_req_ready), 64'h3);
        tick;
        chk("mr_both_valid", 64'(bk_valid), 64'h3);
        for (int r = 0; r < NR; r++) core_req_addr[r] = 30'(2 * r);
        core_req_valid = 4'b1111;
        reset          = 1'b0;
        #1;
        chk("mr_ready_in_reset", 64'(core_req_ready), 64'h0);
        tick;
        chk("mr_valid_cleared", 64'(bk_valid), 64'h0);
        chk("mr_ready_cleared", 64'(core_req_ready), 64'h0);
        reset    = 1'b1;
        bk_ready = 2'b11;
        #1;
        chk("mr_first_winner", 64'(core_req_ready), 64'h1);
        tick;
        chk("mr_idx0", 64'(bk_idx[0]), 64'h0);
        chk("mr_valid0", 64'(bk_valid[0]), 64'h1);
        core_req_valid = '0;
        tick;

        // Single-bank build: address passes through, two lanes alternate.
        s_addr[0]  = 30'h3FF;
        s_addr[1]  = 30'h155;
        s_valid    = 2'b11;
        s_bk_ready = 1'b1;
        #1;
        chk("ob_ready_l0", 64'(s_ready), 64'h1);
        tick;
        chk("ob_valid", 64'(s_bk_valid), 64'h1);
        chk("ob_idx_l0", 64'(s_bk_idx[0]), 64'h0);
        chk("ob_addr_l0", 64'(s_bk_addr[0]), 64'h3FF);
        #1;
        chk("ob_ready_l1", 64'(s_ready), 64'h2);
        tick;
        chk("ob_idx_l1", 64'(s_bk_idx[0]), 64'h1);
        chk("ob_addr_l1", 64'(s_bk_addr[0]), 64'h155);
        tick;
        chk("ob_idx_wrap", 64'(s_bk_idx[0]), 64'h0);
        s_valid = '0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/cache_req_dispatch.md
Name: cache_req_dispatch

Overview:
- Forward-path partner of the cache's bank-to-core response merge.
- Takes NUM_REQS per-lane core word requests and steers each one to the cache bank selected by its address low bits.
- Arbitrates round-robin among lanes that hit the same bank.
- Registers one request per bank in an output pipeline stage. Each bank carries the winning lane index (idx), so the response path can route data back to that lane.

Parameters:
- NUM_REQS, 4: core request lanes; must be >= NUM_BANKS.
- NUM_BANKS, 2: cache banks; must be a power of 2.
- WORD_SIZE, 4: word size in bytes.
- ADDR_WIDTH, 30: core word-address width.
- TAG_WIDTH, 8: core request tag width.
- Derived, not overridable:
  - WORD_WIDTH = WORD_SIZE*8
  - BANK_SEL_BITS = clog2(NUM_BANKS)
  - BANK_ADDR_WIDTH = ADDR_WIDTH-BANK_SEL_BITS
  - REQ_SEL_BITS = LOG2UP(NUM_REQS)

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- core_req_valid  in  [NUM_REQS]  per-lane request valid.
- core_req_rw  in  [NUM_REQS]  1 = write.
- core_req_addr  in  [NUM_REQS][ADDR_WIDTH]  word address.
- core_req_byteen  in  [NUM_REQS][WORD_SIZE]  byte enables.
- core_req_data  in  [NUM_REQS][WORD_WIDTH]  write data.
- core_req_tag  in  [NUM_REQS][TAG_WIDTH]  request tag.
- core_req_ready  out  [NUM_REQS]  lane accepted this cycle.
- per_bank_core_req_valid  out  [NUM_BANKS]  bank request valid.
- per_bank_core_req_rw  out  [NUM_BANKS]  rw.
- per_bank_core_req_addr  out  [NUM_BANKS][BANK_ADDR_WIDTH]  address with bank bits stripped.
- per_bank_core_req_byteen  out  [NUM_BANKS][WORD_SIZE]  byte enables.
- per_bank_core_req_data  out  [NUM_BANKS][WORD_WIDTH]  write data.
- per_bank_core_req_tag  out  [NUM_BANKS][TAG_WIDTH]  tag.
- per_bank_core_req_idx  out  [NUM_BANKS][REQ_SEL_BITS]  originating lane.
- per_bank_core_req_ready  in  [NUM_BANKS]  bank accepts.

Behaviour:
- Bank select:
  - bank = core_req_addr[r][BANK_SEL_BITS-1:0].
  - Bank address = core_req_addr[r][ADDR_WIDTH-1:BANK_SEL_BITS].
  - With NUM_BANKS==1, all lanes target bank 0 and the address passes through unmodified.
- Arbitration, per bank b:
  - Candidates are lanes r with core_req_valid[r] and bank==b.
  - Search starts at rr_ptr[b] and proceeds upward, wrapping modulo NUM_REQS; the first candidate found wins.
  - At most one grant per bank per cycle.
- Stage load, per bank: stage_can_load[b] = !stage_valid[b] || per_bank_core_req_ready[b].
- Lane handshake:
  - core_req_ready[r] = 1 iff lane r holds the grant of its bank AND stage_can_load for that bank.
  - core_req_ready is combinational from valid/addr/ready.
  - A lane that is valid but not granted sees ready=0 and must hold its request.
- On accept (core_req_valid[r] && core_req_ready[r]):
  - Bank stage loads rw/addr/byteen/data/tag/idx=r.
  - stage_valid sets at the next edge.
  - rr_ptr[b] <= (r+1) mod NUM_REQS.
- No accept on bank b: rr_ptr[b] unchanged.
- Output stage:
  - per_bank_core_req_valid = stage_valid.
  - If valid && !ready: hold all fields stable with no new load (stall).
  - If valid && ready && no new grant: stage_valid clears.
  - Fire and accept in the same cycle: replace the contents, no bubble.
- Latency and throughput: 1 cycle from lane accept to bank valid; 1 request per bank per cycle sustained.
- Ordering: requests from the same lane to the same bank issue in acceptance order.
- Reset (reset==0 at a clock edge):
  - stage_valid = 0, so all per_bank_core_req_valid = 0 from the next cycle.
  - rr_ptr = 0 for all banks.
  - Data fields don't-care.
  - Mid-operation reset discards buffered requests; core_req_ready = 0 while reset is asserted.
- Simultaneous events: lanes targeting different banks are all accepted in the same cycle; conflicting lanes serialize per round-robin.
- Static asserts: NUM_BANKS power of 2; NUM_BANKS <= NUM_REQS.

Decomposition:
- Shared cache package holds:
  - bank-select/bank-address helper functions (bank_sel_of(addr), bank_addr_of(addr));
  - the derived width constants (BANK_SEL_BITS, REQ_SEL_BITS).
- One sub-module: cache_req_rr_arbiter (NUM_REQS requests in; one-hot grant + index out; pointer advances on an accept strobe). Instantiate it once per bank.

Test Plan:
- No conflict (NUM_REQS=4, NUM_BANKS=2): lanes 0 and 1 valid with addr 0x10 and 0x11, banks always ready → both core_req_ready=1 same cycle; next cycle bank0 idx=0 addr=0x8 and bank1 idx=1 addr=0x8.
- Conflict fairness: all 4 lanes valid with even addresses, held for 4 cycles, bank0 always ready → grants issue in lane order 0,1,2,3 and bank0 shows idx 0,1,2,3 on consecutive cycles; bank1 valid stays 0.
- Stall: bank1 ready=0 for 3 cycles with a buffered request from lane 2 → stage fields stable for 3 cycles, core_req_ready=0 for lanes targeting bank1; on ready=1 with lane 3 waiting, lane 3 loads the same cycle (no bubble).
- Pointer hold: lane 1 granted but bank stalled → rr_ptr stays 1; after release lane 1 fires first, then lane 2.
- Reset mid-traffic: drive reset=0 while both banks hold valid requests → next edge all per_bank_core_req_valid=0 and core_req_ready=0; after release, lane 0 (ptr=0) wins the first conflict.
- NUM_BANKS=1 build: addr 0x3FF passes through unchanged; 2 lanes valid → alternating idx 0,1.
